snes_pad_responder: RTL and testbench

//  Device end of the SNES-pad serial protocol. The console-side controller block drives

---
 rtl/gba_pad_pkg.sv | 36 +++
 rtl/pad_sync_edge.sv | 34 +++
 rtl/snes_pad_responder.sv | 136 +++++++++++++
 tb/tb_snes_pad_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_pad_pkg.sv
// Purpose: shared types and constants for the SNES-pad responder and its pin synchronizers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gba_pad_pkg;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_LATCH,
    PAD_SHIFT,
    PAD_DONE
  } pad_state_t;

  // Button indices into the 12-bit pressed=1 vector
  localparam int PAD_B      = 0;
  localparam int PAD_Y      = 1;
  localparam int PAD_SELECT = 2;
  localparam int PAD_START  = 3;
  localparam int PAD_UP     = 4;
  localparam int PAD_DOWN   = 5;
  localparam int PAD_LEFT   = 6;
  localparam int PAD_RIGHT  = 7;
  localparam int PAD_A      = 8;
  localparam int PAD_X      = 9;
  localparam int PAD_L      = 10;
  localparam int PAD_R      = 11;

  localparam int PAD_BUTTONS    = 12;
  localparam int PAD_FRAME_BITS = 16;

  // Line is active low: a pressed button drives 0; the top nibble carries the pad ID levels.
  function automatic logic [PAD_FRAME_BITS-1:0] pad_frame(input logic [3:0] id_line,
                                                          input logic [PAD_BUTTONS-1:0] buttons);
    return {id_line, ~buttons};
  endfunction

endpackage

// File: rtl/pad_sync_edge.sv
// Purpose: multi-flop synchronizer for one async pin, with single-cycle rise/fall pulses.
// Latency: level after SYNC_STAGES clk edges; rise/fall pulses valid during the cycle after that.
// Backpressure: none; free-running sampler.
module pad_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchronizer chain and keep one sample of history for edges
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Purpose: device end of the SNES-pad serial protocol; answers latch/clock strobes with a 16-bit frame.
// Latency: pin change to serial_data change is SYNC_STAGES+1 clk cycles; buttons to line is 1 cycle in LATCH.
// Backpressure: none; the console owns the strobes and the watchdog abandons a stalled frame.
module snes_pad_responder
  import gba_pad_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [3:0] ID_LINE        = 4'hF,
  parameter logic       FILL_BIT       = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [PAD_BUTTONS-1:0] buttons,
  input  logic                   data_latch,
  input  logic                   data_clock,
  output logic                   serial_data,
  output logic                   busy,
  output logic [4:0]             bit_index,
  output logic                   frame_done,
  output logic                   timeout
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  pad_state_t                state;
  logic [PAD_FRAME_BITS-1:0] shreg;
  logic [WD_W-1:0]           wd;
  logic [PAD_FRAME_BITS-1:0] frame_word;

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl_unused, clk_rise, clk_fall_unused;

  pad_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_latch_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .pin   (data_latch),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  // data_clock idles high, so its synchronizer resets high to avoid a false rise after reset
  pad_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_clock_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .pin   (data_clock),
    .level (clk_lvl_unused),
    .rise  (clk_rise),
    .fall  (clk_fall_unused)
  );

  assign frame_word  = pad_frame(ID_LINE, buttons);
  assign serial_data = shreg[0];

  // Responder FSM: latch handling, shifting, watchdog and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state      <= PAD_IDLE;
      shreg      <= '1;
      busy       <= 1'b0;
      bit_index  <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      wd         <= '0;
    end else begin
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        PAD_IDLE: begin
          if (latch_lvl) begin
            state     <= PAD_LATCH;
            shreg     <= frame_word;
            bit_index <= '0;
            busy      <= 1'b1;
          end
        end
        PAD_LATCH: begin
          // The word loaded on the last latched cycle is the one that gets shifted out
          if (latch_fall) begin
            state <= PAD_SHIFT;
            wd    <= '0;
          end else begin
            shreg <= frame_word;
          end
        end
        PAD_SHIFT: begin
          // A new latch aborts the frame and takes priority over a coincident clock edge
          if (latch_rise) begin
            state     <= PAD_LATCH;
            shreg     <= frame_word;
            bit_index <= '0;
            busy      <= 1'b1;
          end else if (clk_rise) begin
            shreg     <= {FILL_BIT, shreg[PAD_FRAME_BITS-1:1]};
            bit_index <= bit_index + 5'd1;
            wd        <= '0;
            if (bit_index == 5'(PAD_FRAME_BITS - 1)) begin
              frame_done <= 1'b1;
              state      <= PAD_DONE;
              busy       <= 1'b0;
            end
          end else if (wd == WD_LAST) begin
            timeout <= 1'b1;
            state   <= PAD_IDLE;
            busy    <= 1'b0;
            shreg   <= '1;
            wd      <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        PAD_DONE: begin
          if (latch_lvl) begin
            state     <= PAD_LATCH;
            shreg     <= frame_word;
            bit_index <= '0;
            busy      <= 1'b1;
          end
        end
        default: begin
          state <= PAD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
module tb_snes_pad_responder;

  localparam int         SS   = 2;
  localparam int         TO   = 64;
  localparam logic [3:0] IDL  = 4'h6;
  localparam logic       FB   = 1'b0;
  localparam int         HALF = 6;
  localparam int         SET  = SS + 2;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [11:0] buttons = '0;
  logic        data_latch = 1'b0;
  logic        data_clock = 1'b1;
  logic        serial_data;
  logic        busy;
  logic [4:0]  bit_index;
  logic        frame_done;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int to_cnt = 0;

  snes_pad_responder #(
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TO),
    .ID_LINE        (IDL),
    .FILL_BIT       (FB)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .buttons     (buttons),
    .data_latch  (data_latch),
    .data_clock  (data_clock),
    .serial_data (serial_data),
    .busy        (busy),
    .bit_index   (bit_index),
    .frame_done  (frame_done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Count single-cycle pulses away from the active edge
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame word shifted LSB first, FILL after all 16 bits are out
  function automatic logic [15:0] model_word(input logic [11:0] b);
    return {IDL, ~b};
  endfunction

  function automatic logic model_line(input logic [15:0] w, input int shifts);
    return (shifts < 16) ? w[shifts] : FB;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_in(input logic [11:0] b);
    buttons = b;
    data_latch = 1'b1;
    wait_cyc(8);
    data_latch = 1'b0;
    wait_cyc(SET);
  endtask

  task automatic clk_pulse();
    data_clock = 1'b0;
    wait_cyc(HALF);
    data_clock = 1'b1;
    wait_cyc(HALF);
  endtask

  // Clock n bits starting after 'from' shifts; buttons are scrambled to prove they are frozen
  task automatic shift_check(input string tag, input logic [15:0] w, input int from, input int n);
    for (int k = from + 1; k <= from + n; k++) begin
      clk_pulse();
      buttons = 12'($urandom);
      chk($sformatf("%s_line%0d", tag, k), 32'(serial_data), 32'(model_line(w, k)));
      chk($sformatf("%s_idx%0d", tag, k), 32'(bit_index), (k < 16) ? k : 16);
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy), (k < 16) ? 1 : 0);
    end
  endtask

  initial begin
    logic [15:0] w, w2;
    logic [11:0] b, b2;
    int fd0;
    int n;

    // Reset values
    wait_cyc(3);
    chk("rst_line", 32'(serial_data), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(bit_index), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_to", 32'(timeout), 0);
    rst_b = 1'b1;
    wait_cyc(4);
    chk("idle_line", 32'(serial_data), 1);

    // B pressed, full frame
    w = model_word(12'h001);
    fd0 = fd_cnt;
    latch_in(12'h001);
    chk("t1_line0", 32'(serial_data), 32'(w[0]));
    chk("t1_idx0", 32'(bit_index), 0);
    chk("t1_busy0", 32'(busy), 1);
    shift_check("t1", w, 0, 16);
    chk("t1_fd", fd_cnt, fd0 + 1);

    // Mixed pattern, extra clocks past the frame stay at FILL
    w = model_word(12'hA5A);
    fd0 = fd_cnt;
    latch_in(12'hA5A);
    chk("t2_line0", 32'(serial_data), 32'(w[0]));
    shift_check("t2", w, 0, 20);
    chk("t2_fd", fd_cnt, fd0 + 1);

    // Random frames
    for (int r = 0; r < 3; r++) begin
      b = 12'($urandom);
      w = model_word(b);
      fd0 = fd_cnt;
      latch_in(b);
      chk($sformatf("t3r%0d_line0", r), 32'(serial_data), 32'(w[0]));
      shift_check($sformatf("t3r%0d", r), w, 0, 16);
      chk($sformatf("t3r%0d_fd", r), fd_cnt, fd0 + 1);
    end

    // Line tracks B while latched, then freezes
    buttons = 12'h000;
    data_latch = 1'b1;
    wait_cyc(SET);
    chk("t4_track_a", 32'(serial_data), 1);
    buttons = 12'h001;
    wait_cyc(SET);
    chk("t4_track_b", 32'(serial_data), 0);
    buttons = 12'h000;
    wait_cyc(SET);
    chk("t4_track_c", 32'(serial_data), 1);
    chk("t4_busy", 32'(busy), 1);
    buttons = 12'h001;
    wait_cyc(SET);
    data_latch = 1'b0;
    wait_cyc(SET);
    chk("t4_frozen_a", 32'(serial_data), 0);
    buttons = 12'h000;
    wait_cyc(SET);
    chk("t4_frozen_b", 32'(serial_data), 0);
    chk("t4_idx", 32'(bit_index), 0);

    // Abort after 7 clocks, restart with fresh buttons
    b = 12'($urandom);
    w = model_word(b);
    fd0 = fd_cnt;
    latch_in(b);
    shift_check("t5a", w, 0, 7);
    b2 = 12'($urandom);
    w2 = model_word(b2);
    latch_in(b2);
    chk("t5_line0", 32'(serial_data), 32'(w2[0]));
    chk("t5_idx0", 32'(bit_index), 0);
    shift_check("t5b", w2, 0, 16);
    chk("t5_fd", fd_cnt, fd0 + 1);

    // Watchdog: 3 clocks then silence
    latch_in(12'($urandom));
    clk_pulse();
    clk_pulse();
    data_clock = 1'b0;
    wait_cyc(HALF);
    data_clock = 1'b1;
    n = -1;
    for (int i = 1; i <= 2 * TO + 20; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("t6_to_delay", n, SS + 1 + TO);
    @(negedge clk);
    chk("t6_to_pulse", 32'(timeout), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_line", 32'(serial_data), 1);

    // Reset mid-frame at bit 9 (line driven low there before reset)
    b = 12'($urandom) | 12'h200;
    w = model_word(b);
    latch_in(b);
    shift_check("t7", w, 0, 9);
    chk("t7_pre_line", 32'(serial_data), 0);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("t7_line", 32'(serial_data), 1);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_idx", 32'(bit_index), 0);
    chk("t7_fd", 32'(frame_done), 0);
    chk("t7_to", 32'(timeout), 0);

    // Simultaneous latch and clock rise: latch wins
    b = 12'($urandom);
    w = model_word(b);
    fd0 = fd_cnt;
    latch_in(b);
    shift_check("t8a", w, 0, 4);
    data_clock = 1'b0;
    wait_cyc(HALF);
    b2 = 12'($urandom);
    b2[0] = w[4];
    w2 = model_word(b2);
    buttons = b2;
    data_latch = 1'b1;
    data_clock = 1'b1;
    wait_cyc(SET);
    chk("t8_idx", 32'(bit_index), 0);
    chk("t8_busy", 32'(busy), 1);
    chk("t8_line", 32'(serial_data), 32'(w2[0]));
    data_latch = 1'b0;
    wait_cyc(SET);
    chk("t8_line_shift", 32'(serial_data), 32'(w2[0]));
    shift_check("t8b", w2, 0, 16);
    chk("t8_fd", fd_cnt, fd0 + 1);

    chk("total_timeouts", to_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
